// File: rtl/and_gate_pkg.sv
// and_gate_pkg: default sizing shared by the and_gate cell and its hit counter
package and_gate_pkg;
   localparam int unsigned WIDTH_DEF = 1;
   localparam int unsigned CNT_W_DEF = 8;
endpackage

// File: rtl/and_gate_sat_cnt.sv
// and_gate_sat_cnt: saturating event counter with sticky saturation flag
//   clk/rst_n : clock, asynchronous active-low reset
//   inc       : count one event this cycle
//   clr       : synchronous clear of cnt and sat, wins over inc
//   cnt       : event count, holds at all-ones
//   sat       : set on the edge cnt reaches all-ones, sticky until clr/reset
module and_gate_sat_cnt
   import and_gate_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             sat_d, sat_q;
   // sat rises together with the increment that lands on CNT_MAX
   always_comb begin
      cnt_d = clr ? '0 : (inc && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
      sat_d = clr ? 1'b0 : sat_q | (inc && cnt_q >= CNT_MAX - 1'b1);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sat_q <= sat_d;
      end
   assign cnt = cnt_q;
   assign sat = sat_q;
endmodule

// File: rtl/and_gate.sv
// and_gate: bitwise AND with registered copy, AND-reduce flag and all-ones hit counter
//   clk/rst_n : clock, asynchronous active-low reset
//   a, b      : operands
//   clr       : synchronous clear of hit_cnt and sat
//   y         : combinational a & b
//   y_q       : registered a & b
//   all_q     : registered AND-reduce of a & b
//   hit_cnt   : saturating count of cycles with a & b all ones
//   sat       : hit_cnt has reached its maximum (sticky)
module and_gate
   import and_gate_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             clr,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             all_q,
   output logic [CNT_W-1:0] hit_cnt,
   output logic             sat
);
   logic hit;
   assign y   = a & b;
   assign hit = &y;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         y_q   <= '0;
         all_q <= 1'b0;
      end else begin
         y_q   <= y;
         all_q <= hit;
      end
   and_gate_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (hit),
      .clr  (clr),
      .cnt  (hit_cnt),
      .sat  (sat)
   );
endmodule

// File: tb/tb_and_gate.sv
// tb_and_gate: randomized and directed checks of and_gate against a behavioural model
module tb_and_gate;
   logic       clk = 1'b0, clk_en = 1'b1, rst_n = 1'b0, clr = 1'b0;
   logic       a1 = 1'b0, b1 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       y1, y_q1, all_q1, sat1;
   logic [2:0] hit_cnt1;
   logic [3:0] y4, y_q4;
   logic       all_q4, sat4;
   logic [7:0] hit_cnt4;
   int passed = 0, total = 0;
   logic       e_yq1, e_all1, e_sat1, e_all4, e_sat4;
   logic [3:0] e_yq4;
   int         e_cnt1, e_cnt4;

   always #5 if (clk_en || clk) clk = ~clk;

   and_gate #(.WIDTH(1), .CNT_W(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .clr(clr),
      .y(y1), .y_q(y_q1), .all_q(all_q1), .hit_cnt(hit_cnt1), .sat(sat1));
   and_gate #(.WIDTH(4), .CNT_W(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .clr(clr),
      .y(y4), .y_q(y_q4), .all_q(all_q4), .hit_cnt(hit_cnt4), .sat(sat4));

   task automatic model_reset();
      e_yq1 = 0; e_all1 = 0; e_cnt1 = 0; e_sat1 = 0;
      e_yq4 = 0; e_all4 = 0; e_cnt4 = 0; e_sat4 = 0;
   endtask

   task automatic count(input bit hit, input int max, inout int cnt, inout logic s);
      if (clr) begin
         cnt = 0; s = 0;
      end else if (hit) begin
         if (cnt < max) cnt++;
         if (cnt == max) s = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
         e_yq1 = a1 & b1; e_all1 = (a1 == 1'b1 && b1 == 1'b1);
         e_yq4 = a4 & b4; e_all4 = (a4 == 4'hF && b4 == 4'hF);
         count(e_all1, 7, e_cnt1, e_sat1);
         count(e_all4, 255, e_cnt4, e_sat4);
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0; model_reset();
      a4 = 4'b0110; b4 = 4'b1100;
      tick(); tick();
      total++;
      if ({y_q1, all_q1, hit_cnt1, sat1, y_q4, all_q4, hit_cnt4, sat4} !== '0)
         $display("FAIL reset_state got %b required all zero",
                  {y_q1, all_q1, hit_cnt1, sat1, y_q4, all_q4, hit_cnt4, sat4});
      else passed++;
      total++;
      if (y4 !== 4'b0100) $display("FAIL reset_y_comb got %b required 0100", y4);
      else passed++;
      #2 rst_n = 1;
      tick();
   endtask

   task automatic test_truth_table();
      clk_en = 0; #10;
      for (int i = 0; i < 4; i++) begin
         a1 = i[1]; b1 = i[0];
         #1;
         total++;
         if (y1 !== (i == 3)) $display("FAIL truth_%0d%0d got %b required %b", i[1], i[0], y1, i == 3);
         else passed++;
      end
   endtask

   task automatic test_latency();
      rst_n = 0; model_reset();
      a1 = 1; b1 = 1;
      #1;
      total++;
      if (y1 !== 1'b1) $display("FAIL latency_y got %b required 1", y1);
      else passed++;
      rst_n = 1; #1;
      total++;
      if ({y_q1, all_q1} !== 2'b00) $display("FAIL latency_before_edge got %b required 00", {y_q1, all_q1});
      else passed++;
      clk_en = 1;
      tick();
      total++;
      if ({y_q1, all_q1} !== 2'b11) $display("FAIL latency_after_edge got %b required 11", {y_q1, all_q1});
      else passed++;
   endtask

   task automatic test_width4();
      int c;
      a4 = 4'b1011; b4 = 4'b1110; c = hit_cnt4;
      #1;
      total++;
      if (y4 !== 4'b1010) $display("FAIL w4_y got %b required 1010", y4);
      else passed++;
      tick();
      total++;
      if ({y_q4, all_q4} !== 5'b10100) $display("FAIL w4_regs got %b required 10100", {y_q4, all_q4});
      else passed++;
      total++;
      if (hit_cnt4 !== 8'(c)) $display("FAIL w4_cnt_hold got %0d required %0d", hit_cnt4, c);
      else passed++;
   endtask

   task automatic test_saturation();
      clr = 1; tick(); clr = 0;
      a1 = 1; b1 = 1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         total++;
         if (hit_cnt1 !== 3'((i < 7) ? i : 7) || sat1 !== (i >= 7))
            $display("FAIL sat_cycle%0d got cnt=%0d sat=%b required cnt=%0d sat=%b",
                     i, hit_cnt1, sat1, (i < 7) ? i : 7, i >= 7);
         else passed++;
      end
   endtask

   task automatic test_clear_priority();
      clr = 1; tick(); clr = 0;
      a1 = 1; b1 = 1;
      repeat (5) tick();
      total++;
      if (hit_cnt1 !== 3'd5) $display("FAIL clr_setup got %0d required 5", hit_cnt1);
      else passed++;
      clr = 1; tick(); clr = 0;
      total++;
      if ({hit_cnt1, sat1} !== 4'b0000) $display("FAIL clr_wins got cnt=%0d sat=%b required 0 0", hit_cnt1, sat1);
      else passed++;
      tick();
      total++;
      if (hit_cnt1 !== 3'd1) $display("FAIL clr_next_hit got %0d required 1", hit_cnt1);
      else passed++;
   endtask

   task automatic test_async_reset();
      clr = 1; tick(); clr = 0;
      a1 = 1; b1 = 1;
      repeat (4) tick();
      total++;
      if (hit_cnt1 !== 3'd4) $display("FAIL arst_setup got %0d required 4", hit_cnt1);
      else passed++;
      #2 rst_n = 0; model_reset();
      #1;
      total++;
      if ({y_q1, all_q1, hit_cnt1, sat1} !== '0)
         $display("FAIL arst_immediate got %b required 000000", {y_q1, all_q1, hit_cnt1, sat1});
      else passed++;
      b1 = 0; #1;
      total++;
      if (y1 !== 1'b0) $display("FAIL arst_y_tracks got %b required 0", y1);
      else passed++;
      tick();
      rst_n = 1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         a1 = 1'($urandom); b1 = 1'($urandom);
         a4 = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
         b4 = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
         clr = ($urandom_range(0, 15) == 0);
         #1;
         total++;
         if (y1 !== (a1 & b1) || y4 !== (a4 & b4))
            $display("FAIL rand_y%0d got %b/%b required %b/%b", i, y1, y4, a1 & b1, a4 & b4);
         else passed++;
         tick();
         total++;
         if ({y_q1, all_q1, hit_cnt1, sat1} !== {e_yq1, e_all1, 3'(e_cnt1), e_sat1} ||
             {y_q4, all_q4, hit_cnt4, sat4} !== {e_yq4, e_all4, 8'(e_cnt4), e_sat4})
            $display("FAIL rand_regs%0d got %b %b required %b %b", i,
                     {y_q1, all_q1, hit_cnt1, sat1}, {y_q4, all_q4, hit_cnt4, sat4},
                     {e_yq1, e_all1, 3'(e_cnt1), e_sat1}, {e_yq4, e_all4, 8'(e_cnt4), e_sat4});
         else passed++;
      end
      clr = 0;
   endtask

   task automatic test_sat_default();
      clr = 1; tick(); clr = 0;
      a4 = 4'hF; b4 = 4'hF;
      for (int i = 1; i <= 258; i++) begin
         tick();
         if (i >= 254) begin
            total++;
            if (hit_cnt4 !== 8'((i < 255) ? i : 255) || sat4 !== (i >= 255))
               $display("FAIL sat8_cycle%0d got cnt=%0d sat=%b required cnt=%0d sat=%b",
                        i, hit_cnt4, sat4, (i < 255) ? i : 255, i >= 255);
            else passed++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_truth_table();
      test_latency();
      test_width4();
      test_saturation();
      test_clear_priority();
      test_async_reset();
      test_random();
      test_sat_default();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
